// File: rtl/vpg_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vpg_timing_gen
//  Description : Parametrised video raster timing generator with run-time
//                selectable RGB test patterns (solid, colour bars, grey ramp,
//                grid, checkerboard, optional moving box).
//                Stage 0 holds the h/v counters and decode; stage 1 registers
//                every output, so all outputs share one clock of latency.
//  Options     : define VPG_MOVING_BOX_EN to enable the mode-5 moving box.
//  Revision    : 1.0 - initial release
// ============================================================================
module vpg_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [2:0]             mode_sel,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic                   vpg_de,
  output logic                   vpg_hs,
  output logic                   vpg_vs,
  output logic [COLOR_W-1:0]     vpg_r,
  output logic [COLOR_W-1:0]     vpg_g,
  output logic [COLOR_W-1:0]     vpg_b,
  output logic                   frame_start,
  output logic [15:0]            frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  // One spare bit so sync-end compares stay exact even with a zero back porch
  localparam int HX      = HW + 1;
  localparam int VX      = VW + 1;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int PW      = 3 * COLOR_W;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [HX-1:0] HS_START   = HX'(H_ACTIVE + H_FP);
  localparam logic [HX-1:0] HS_END     = HX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VX-1:0] VS_START   = VX'(V_ACTIVE + V_FP);
  localparam logic [VX-1:0] VS_END     = VX'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [COLOR_W-1:0] FULL = '1;
  localparam logic [COLOR_W-1:0] ZERO = '0;

  // Stage 0 state
  logic [HW-1:0]  h_cnt_q, h_cnt_d;
  logic [VW-1:0]  v_cnt_q, v_cnt_d;
  logic [2:0]     mode_q, mode_d;
  logic [PW-1:0]  solid_q, solid_d;
  logic           fs_now;

  // Stage 1 (output) state
  logic           de_q, de_d;
  logic           hs_q, hs_d;
  logic           vs_q, vs_d;
  logic [PW-1:0]  pix_q, pix_d;
  logic           fs_q;
  logic [15:0]    frame_cnt_q, frame_cnt_d;

  // Pattern helpers
  logic [2:0]     bar_idx;
  logic [2:0]     bar_rgb;
  logic           grid_on;
  logic           check_on;
  logic [HX-1:0]  h_ext;
  logic [VX-1:0]  v_ext;

  // Raster counters, frame-start detection and shadow register next-state
  always_comb begin
    fs_now  = (h_cnt_q == '0) && (v_cnt_q == '0);
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
    // The frame-start pixel itself already uses the freshly sampled settings
    mode_d      = fs_now ? mode_sel  : mode_q;
    solid_d     = fs_now ? solid_rgb : solid_q;
    frame_cnt_d = fs_now ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  // Timing decode for DE and the two sync outputs
  always_comb begin
    h_ext = {1'b0, h_cnt_q};
    v_ext = {1'b0, v_cnt_q};
    de_d  = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
    hs_d  = ((h_ext >= HS_START) && (h_ext < HS_END)) ? HS_POL : ~HS_POL;
    vs_d  = ((v_ext >= VS_START) && (v_ext < VS_END)) ? VS_POL : ~VS_POL;
  end

  // Colour-bar index from a comparator chain against the bar boundaries
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt_q >= HW'(k * BAR_W)) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
    case (bar_idx)
      3'd0:    bar_rgb = 3'b111;  // white
      3'd1:    bar_rgb = 3'b110;  // yellow
      3'd2:    bar_rgb = 3'b011;  // cyan
      3'd3:    bar_rgb = 3'b010;  // green
      3'd4:    bar_rgb = 3'b101;  // magenta
      3'd5:    bar_rgb = 3'b100;  // red
      3'd6:    bar_rgb = 3'b001;  // blue
      default: bar_rgb = 3'b000;  // black
    endcase
  end

  // Grid lines every 32 pixels plus a border on the last active column/row
  always_comb begin
    grid_on  = (h_cnt_q[4:0] == 5'd0) || (v_cnt_q[4:0] == 5'd0) ||
               (h_cnt_q == H_ACT_LAST) || (v_cnt_q == V_ACT_LAST);
    check_on = h_cnt_q[5] ^ v_cnt_q[5];
  end

`ifdef VPG_MOVING_BOX_EN
  localparam logic [HW-1:0] BX_LIM = HW'(H_ACTIVE - 64);
  localparam logic [VW-1:0] BY_LIM = VW'(V_ACTIVE - 64);

  logic [HW-1:0] bx_q, bx_d;
  logic [VW-1:0] by_q, by_d;
  logic          bx_pos_q, bx_pos_d;
  logic          by_pos_q, by_pos_d;
  logic          in_box;

  // Bounce the box origin by one pixel per frame on each axis
  always_comb begin
    bx_d     = bx_q;
    by_d     = by_q;
    bx_pos_d = bx_pos_q;
    by_pos_d = by_pos_q;
    if (fs_now) begin
      if (bx_pos_q) begin
        if (bx_q >= BX_LIM) begin
          bx_pos_d = 1'b0;
          if (bx_q != '0) bx_d = bx_q - HW'(1);
        end else begin
          bx_d = bx_q + HW'(1);
        end
      end else begin
        if (bx_q == '0) begin
          bx_pos_d = 1'b1;
          if (bx_q < BX_LIM) bx_d = bx_q + HW'(1);
        end else begin
          bx_d = bx_q - HW'(1);
        end
      end
      if (by_pos_q) begin
        if (by_q >= BY_LIM) begin
          by_pos_d = 1'b0;
          if (by_q != '0) by_d = by_q - VW'(1);
        end else begin
          by_d = by_q + VW'(1);
        end
      end else begin
        if (by_q == '0) begin
          by_pos_d = 1'b1;
          if (by_q < BY_LIM) by_d = by_q + VW'(1);
        end else begin
          by_d = by_q - VW'(1);
        end
      end
    end
    // bx_d/by_d equal the held origin except on the frame-start pixel
    in_box = (h_ext >= {1'b0, bx_d}) && (h_ext < ({1'b0, bx_d} + HX'(64))) &&
             (v_ext >= {1'b0, by_d}) && (v_ext < ({1'b0, by_d} + VX'(64)));
  end

  // Box origin and direction registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bx_q     <= '0;
      by_q     <= '0;
      bx_pos_q <= 1'b1;
      by_pos_q <= 1'b1;
    end else begin
      bx_q     <= bx_d;
      by_q     <= by_d;
      bx_pos_q <= bx_pos_d;
      by_pos_q <= by_pos_d;
    end
  end
`endif

  // Pattern multiplexer; blanking forces black
  always_comb begin
    pix_d = '0;
    if (de_d) begin
      case (mode_d)
        3'd0: pix_d = solid_d;
        3'd1: pix_d = {{COLOR_W{bar_rgb[2]}}, {COLOR_W{bar_rgb[1]}}, {COLOR_W{bar_rgb[0]}}};
        3'd2: pix_d = {3{COLOR_W'(h_cnt_q)}};
        3'd3: pix_d = grid_on  ? {FULL, FULL, FULL} : {ZERO, ZERO, ZERO};
        3'd4: pix_d = check_on ? {FULL, FULL, FULL} : {ZERO, ZERO, ZERO};
`ifdef VPG_MOVING_BOX_EN
        3'd5: pix_d = in_box ? {FULL, ZERO, ZERO} : {ZERO, ZERO, FULL};
`endif
        default: pix_d = '0;
      endcase
    end
  end

  // Stage 0 registers: counters and frame-start shadow copies
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      mode_q  <= 3'd1;
      solid_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
    end
  end

  // Stage 1 registers: all outputs, mutually aligned
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_q        <= 1'b0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      pix_q       <= '0;
      fs_q        <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      pix_q       <= pix_d;
      fs_q        <= fs_now;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vpg_de      = de_q;
  assign vpg_hs      = hs_q;
  assign vpg_vs      = vs_q;
  assign vpg_r       = pix_q[3*COLOR_W-1:2*COLOR_W];
  assign vpg_g       = pix_q[2*COLOR_W-1:COLOR_W];
  assign vpg_b       = pix_q[COLOR_W-1:0];
  assign frame_start = fs_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire
